// File: rtl/al_key_entry.sv
`timescale 1ns/1ps
// al_key_entry: PS/2 time/alarm entry controller. Decodes T|A, four
// BCD digits and Enter into a validated HHMM load strobe.
// Ports: clk, reset_n (async, active low), key_code/key_valid (scan-code
// byte strobe), sec_tick (1 Hz pulse); digits/digit_count (entry
// buffer), entry_active, entry_is_alarm, load_time, load_alarm, error.
module al_key_entry #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  key_code,
    input  logic        key_valid,
    input  logic        sec_tick,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic        entry_active,
    output logic        entry_is_alarm,
    output logic        load_time,
    output logic        load_alarm,
    output logic        error
);

    localparam int TW = (TIMEOUT_SEC < 1) ? 1 : $clog2(TIMEOUT_SEC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_SEC);

    localparam logic [7:0] K_BRK   = 8'hF0;
    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_T     = 8'h2C;
    localparam logic [7:0] K_A     = 8'h1C;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_BS    = 8'h66;
    localparam logic [7:0] K_ESC   = 8'h76;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ENTRY_TIME  = 2'd1,
        ENTRY_ALARM = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [15:0]   digits_n;
    logic [2:0]    count_n;
    logic [TW-1:0] timer, timer_n;
    logic          break_pending, brk_n;
    logic          lt_n, la_n, err_n;
    logic          make;
    logic          is_digit;
    logic [3:0]    dval;
    logic          hhmm_ok;

    always_comb begin
        is_digit = 1'b1;
        dval     = 4'd0;
        case (key_code)
            8'h45:   dval = 4'd0;
            8'h16:   dval = 4'd1;
            8'h1E:   dval = 4'd2;
            8'h26:   dval = 4'd3;
            8'h25:   dval = 4'd4;
            8'h2E:   dval = 4'd5;
            8'h36:   dval = 4'd6;
            8'h3D:   dval = 4'd7;
            8'h3E:   dval = 4'd8;
            8'h46:   dval = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // Hours 00-23, minutes 00-59, and a full four-digit buffer.
    assign hhmm_ok = (digit_count == 3'd4)
                  && (digits[15:12] <= 4'd2)
                  && (digits[11:8] <= 4'd9)
                  && ((digits[15:12] != 4'd2) || (digits[11:8] <= 4'd3))
                  && (digits[7:4] <= 4'd5)
                  && (digits[3:0] <= 4'd9);

    // A prefix byte leaves break_pending untouched; otherwise a pending
    // break swallows exactly one byte.
    assign make = key_valid && (key_code != K_EXT)
               && (key_code != K_BRK) && !break_pending;

    always_comb begin
        state_n  = state;
        digits_n = digits;
        count_n  = digit_count;
        timer_n  = timer;
        brk_n    = break_pending;
        lt_n     = 1'b0;
        la_n     = 1'b0;
        err_n    = 1'b0;

        if (key_valid && (key_code != K_EXT)) begin
            if (break_pending) brk_n = 1'b0;
            else if (key_code == K_BRK) brk_n = 1'b1;
        end

        if (state == IDLE) begin
            if (make && (key_code == K_T || key_code == K_A)) begin
                state_n  = (key_code == K_T) ? ENTRY_TIME : ENTRY_ALARM;
                digits_n = 16'h0000;
                count_n  = 3'd0;
                timer_n  = '0;
            end
        end else if (make) begin
            timer_n = '0;
            if (is_digit) begin
                if (digit_count < 3'd4) begin
                    digits_n = {digits[11:0], dval};
                    count_n  = digit_count + 3'd1;
                end
            end else begin
                case (key_code)
                    K_BS: begin
                        if (digit_count != 3'd0) begin
                            digits_n = {4'h0, digits[15:4]};
                            count_n  = digit_count - 3'd1;
                        end
                    end
                    K_ENTER: begin
                        if (hhmm_ok) begin
                            lt_n    = (state == ENTRY_TIME);
                            la_n    = (state == ENTRY_ALARM);
                            state_n = IDLE;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    K_ESC: state_n = IDLE;
                    K_T, K_A: begin
                        state_n  = (key_code == K_T) ? ENTRY_TIME : ENTRY_ALARM;
                        digits_n = 16'h0000;
                        count_n  = 3'd0;
                    end
                    default: ;
                endcase
            end
        end else if (sec_tick) begin
            if (timer != TMAX) timer_n = timer + TW'(1);
            if (timer_n == TMAX) state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            digits        <= 16'h0000;
            digit_count   <= 3'd0;
            timer         <= '0;
            break_pending <= 1'b0;
            load_time     <= 1'b0;
            load_alarm    <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            digits        <= digits_n;
            digit_count   <= count_n;
            timer         <= timer_n;
            break_pending <= brk_n;
            load_time     <= lt_n;
            load_alarm    <= la_n;
            error         <= err_n;
        end
    end

    assign entry_active   = (state != IDLE);
    assign entry_is_alarm = (state == ENTRY_ALARM);

endmodule

// File: tb/tb_al_key_entry.sv
`timescale 1ns/1ps
// tb_al_key_entry: directed and randomized checks of al_key_entry
// against a queue-based model of the entry rules.
module tb_al_key_entry;

    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic        key_valid = 1'b0;
    logic        sec_tick = 1'b0;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        entry_active;
    logic        entry_is_alarm;
    logic        load_time;
    logic        load_alarm;
    logic        error;

    al_key_entry #(.TIMEOUT_SEC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .key_code(key_code), .key_valid(key_valid), .sec_tick(sec_tick),
        .digits(digits), .digit_count(digit_count),
        .entry_active(entry_active), .entry_is_alarm(entry_is_alarm),
        .load_time(load_time), .load_alarm(load_alarm), .error(error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Observed strobe counts, sampled mid-cycle.
    int obs_lt = 0, obs_la = 0, obs_err = 0, obs_multi = 0;
    always @(negedge clk) begin
        if (load_time) obs_lt++;
        if (load_alarm) obs_la++;
        if (error) obs_err++;
        if (int'(load_time) + int'(load_alarm) + int'(error) > 1) obs_multi++;
    end

    // Model: mode 0 idle, 1 time, 2 alarm; buffer is the list of digits.
    int mode = 0;
    int dq[$];
    bit brk = 0;
    int secs = 0;
    int exp_lt = 0, exp_la = 0, exp_err = 0;

    function automatic int key_digit(input logic [7:0] c);
        logic [7:0] tab [10];
        tab = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 10; i++) if (tab[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [15:0] exp_digits();
        int v = 0;
        foreach (dq[i]) v = v * 16 + dq[i];
        return 16'(v);
    endfunction

    task automatic model_reset();
        mode = 0; dq.delete(); brk = 0; secs = 0;
    endtask

    task automatic model(input bit kv, input logic [7:0] c, input bit tk);
        bit mk = 0;
        int d;
        if (kv) begin
            if (c == 8'hE0) mk = 0;
            else if (brk) brk = 0;
            else if (c == 8'hF0) brk = 1;
            else mk = 1;
        end
        d = key_digit(c);
        if (mode == 0) begin
            if (mk && (c == 8'h2C || c == 8'h1C)) begin
                mode = (c == 8'h2C) ? 1 : 2; dq.delete(); secs = 0;
            end
        end else if (mk) begin
            secs = 0;
            if (d >= 0) begin
                if (dq.size() < 4) dq.push_back(d);
            end else if (c == 8'h66) begin
                if (dq.size() > 0) void'(dq.pop_back());
            end else if (c == 8'h5A) begin
                if (dq.size() == 4 && dq[0] * 10 + dq[1] <= 23
                    && dq[2] * 10 + dq[3] <= 59) begin
                    if (mode == 1) exp_lt++; else exp_la++;
                    mode = 0;
                end else exp_err++;
            end else if (c == 8'h76) begin
                mode = 0;
            end else if (c == 8'h2C || c == 8'h1C) begin
                mode = (c == 8'h2C) ? 1 : 2; dq.delete();
            end
        end else if (tk) begin
            secs++;
            if (secs >= TO) mode = 0;
        end
    endtask

    task automatic step(input bit kv, input logic [7:0] c, input bit tk);
        @(negedge clk);
        key_valid = kv; key_code = c; sec_tick = tk;
        model(kv, c, tk);
        @(posedge clk); #1;
        key_valid = 0; sec_tick = 0;
    endtask

    task automatic key(input logic [7:0] c);
        step(1, c, 0);
        step(0, 8'h00, 0);
    endtask

    task automatic press(input logic [7:0] c);
        key(c); key(8'hF0); key(c);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({digits, digit_count, entry_active, entry_is_alarm,
             load_time, load_alarm, error} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%0d/%b%b%b%b%b want 0",
                     digits, digit_count, entry_active, entry_is_alarm,
                     load_time, load_alarm, error);
        end
    endtask

    task automatic test_time_commit();
        int lt0 = obs_lt, la0 = obs_la, e0 = obs_err;
        press(8'h2C); press(8'h16); press(8'h1E);
        press(8'h26); press(8'h25); press(8'h5A);
        n_cmp++;
        if (obs_lt - lt0 !== 1 || obs_la != la0 || obs_err != e0) begin
            n_fail++;
            $display("FAIL time_commit_strobes: got lt%0d la%0d err%0d want 1 0 0",
                     obs_lt - lt0, obs_la - la0, obs_err - e0);
        end
        n_cmp++;
        if (digits !== 16'h1234 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL time_commit_state: got %h act%b want 1234 act0",
                     digits, entry_active);
        end
    endtask

    task automatic test_alarm_backspace();
        int la0 = obs_la;
        key(8'h1C); key(8'h45); key(8'h3D); key(8'h46);
        key(8'h66); key(8'h26); key(8'h45);
        n_cmp++;
        if (entry_is_alarm !== 1'b1 || digits !== 16'h0730) begin
            n_fail++;
            $display("FAIL alarm_entry: got alm%b %h want alm1 0730",
                     entry_is_alarm, digits);
        end
        key(8'h5A);
        n_cmp++;
        if (obs_la - la0 !== 1 || digits !== 16'h0730) begin
            n_fail++;
            $display("FAIL alarm_commit: got la%0d %h want la1 0730",
                     obs_la - la0, digits);
        end
    endtask

    task automatic test_range();
        int e0 = obs_err, lt0;
        key(8'h2C); key(8'h1E); key(8'h25); key(8'h45); key(8'h45);
        key(8'h5A);
        n_cmp++;
        if (obs_err - e0 !== 1 || entry_active !== 1'b1 || digits !== 16'h2400) begin
            n_fail++;
            $display("FAIL range_2400: got err%0d act%b %h want err1 act1 2400",
                     obs_err - e0, entry_active, digits);
        end
        repeat (4) key(8'h66);
        n_cmp++;
        if (digit_count !== 3'd0 || digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL range_bs4: got %0d %h want 0 0000", digit_count, digits);
        end
        key(8'h66);
        lt0 = obs_lt;
        key(8'h1E); key(8'h26); key(8'h2E); key(8'h46); key(8'h5A);
        n_cmp++;
        if (obs_lt - lt0 !== 1 || digits !== 16'h2359 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL range_2359: got lt%0d %h act%b want lt1 2359 act0",
                     obs_lt - lt0, digits, entry_active);
        end
        e0 = obs_err;
        key(8'h2C); key(8'h16); key(8'h1E); key(8'h36); key(8'h45);
        key(8'h5A);
        n_cmp++;
        if (obs_err - e0 !== 1 || entry_active !== 1'b1) begin
            n_fail++;
            $display("FAIL range_1260: got err%0d act%b want err1 act1",
                     obs_err - e0, entry_active);
        end
        key(8'h76);
    endtask

    task automatic test_short_overflow();
        int e0 = obs_err, lt0;
        key(8'h2C); key(8'h16); key(8'h1E); key(8'h5A);
        n_cmp++;
        if (obs_err - e0 !== 1 || digit_count !== 3'd2 || entry_active !== 1'b1) begin
            n_fail++;
            $display("FAIL short_entry: got err%0d cnt%0d act%b want 1 2 1",
                     obs_err - e0, digit_count, entry_active);
        end
        lt0 = obs_lt;
        key(8'h26); key(8'h25); key(8'h2E);
        n_cmp++;
        if (digit_count !== 3'd4 || digits !== 16'h1234) begin
            n_fail++;
            $display("FAIL overflow_digit: got cnt%0d %h want 4 1234",
                     digit_count, digits);
        end
        key(8'h5A);
        n_cmp++;
        if (obs_lt - lt0 !== 1 || digits !== 16'h1234) begin
            n_fail++;
            $display("FAIL overflow_commit: got lt%0d %h want lt1 1234",
                     obs_lt - lt0, digits);
        end
    endtask

    task automatic test_break_ext();
        int lt0 = obs_lt;
        key(8'h2C); key(8'hF0); key(8'h2C);
        key(8'h16); key(8'hF0); key(8'h16);
        key(8'hF0); key(8'h45);
        key(8'h46); key(8'h2E); key(8'h46);
        n_cmp++;
        if (digits !== 16'h1959 || digit_count !== 3'd4) begin
            n_fail++;
            $display("FAIL break_ignored: got %h cnt%0d want 1959 4",
                     digits, digit_count);
        end
        key(8'hE0); key(8'h5A);
        n_cmp++;
        if (obs_lt - lt0 !== 1 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL keypad_enter: got lt%0d act%b want lt1 act0",
                     obs_lt - lt0, entry_active);
        end
        key(8'hE0); key(8'hF0); key(8'h5A);
    endtask

    task automatic test_timeout();
        int s0 = obs_lt + obs_la + obs_err;
        key(8'h2C); key(8'h2E);
        step(0, 8'h00, 1); step(0, 8'h00, 0);
        step(0, 8'h00, 1); step(0, 8'h00, 0);
        n_cmp++;
        if (entry_active !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got act%b want act1", entry_active);
        end
        step(0, 8'h00, 1); step(0, 8'h00, 0);
        n_cmp++;
        if (entry_active !== 1'b0 || digits !== 16'h0005
            || obs_lt + obs_la + obs_err != s0) begin
            n_fail++;
            $display("FAIL timeout_abort: got act%b %h strobes%0d want act0 0005 0",
                     entry_active, digits, obs_lt + obs_la + obs_err - s0);
        end
    endtask

    task automatic test_tick_collide();
        key(8'h2C); key(8'h2E);
        step(0, 8'h00, 1); step(0, 8'h00, 0);
        step(0, 8'h00, 1); step(0, 8'h00, 0);
        step(1, 8'h36, 1); step(0, 8'h00, 0);
        repeat (2) begin step(0, 8'h00, 1); step(0, 8'h00, 0); end
        n_cmp++;
        if (entry_active !== 1'b1 || digits !== 16'h0056) begin
            n_fail++;
            $display("FAIL tick_collide_hold: got act%b %h want act1 0056",
                     entry_active, digits);
        end
        step(0, 8'h00, 1); step(0, 8'h00, 0);
        n_cmp++;
        if (entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_collide_expire: got act%b want act0", entry_active);
        end
    endtask

    task automatic test_esc();
        int s0 = obs_lt + obs_la + obs_err;
        key(8'h1C); key(8'h16); key(8'h76);
        n_cmp++;
        if (entry_active !== 1'b0 || obs_lt + obs_la + obs_err != s0
            || digits !== 16'h0001) begin
            n_fail++;
            $display("FAIL esc_abort: got act%b %h strobes%0d want act0 0001 0",
                     entry_active, digits, obs_lt + obs_la + obs_err - s0);
        end
    endtask

    task automatic test_reset_mid();
        key(8'h2C); key(8'h16); key(8'h1E); key(8'hF0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({digits, digit_count, entry_active, entry_is_alarm,
             load_time, load_alarm, error} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h/%0d/%b%b want all 0",
                     digits, digit_count, entry_active, entry_is_alarm);
        end
        @(negedge clk); reset_n = 1'b1;
        key(8'h2C);
        n_cmp++;
        if (entry_active !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_break_cleared: got act%b want act1", entry_active);
        end
        key(8'h76);
    endtask

    task automatic test_random();
        int r;
        logic [7:0] c;
        logic [7:0] dtab [10];
        dtab = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 40) c = dtab[$urandom_range(0, 9)];
            else if (r < 48) c = 8'h66;
            else if (r < 58) c = 8'h5A;
            else if (r < 61) c = 8'h76;
            else if (r < 68) c = 8'h2C;
            else if (r < 74) c = 8'h1C;
            else if (r < 82) c = 8'hF0;
            else if (r < 86) c = 8'hE0;
            else c = 8'($urandom_range(0, 255));
            step(1, c, ($urandom_range(0, 4) == 0));
            step(0, 8'h00, ($urandom_range(0, 3) == 0));
            n_cmp++;
            if (digits !== exp_digits() || digit_count !== 3'(dq.size())
                || entry_active !== (mode != 0) || entry_is_alarm !== (mode == 2)) begin
                n_fail++;
                $display("FAIL random_state it%0d: got %h/%0d/%b%b want %h/%0d/mode%0d",
                         it, digits, digit_count, entry_active, entry_is_alarm,
                         exp_digits(), dq.size(), mode);
            end
            n_cmp++;
            if (obs_lt != exp_lt || obs_la != exp_la || obs_err != exp_err) begin
                n_fail++;
                $display("FAIL random_strobes it%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         it, obs_lt, obs_la, obs_err, exp_lt, exp_la, exp_err);
            end
        end
    endtask

    task automatic test_exclusion();
        n_cmp++;
        if (obs_multi != 0) begin
            n_fail++;
            $display("FAIL strobe_exclusion: got %0d overlapping cycles want 0",
                     obs_multi);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); reset_n = 1'b1;
        test_time_commit();
        test_alarm_backspace();
        test_range();
        test_short_overflow();
        test_break_ext();
        test_timeout();
        test_tick_collide();
        test_esc();
        test_reset_mid();
        test_random();
        test_exclusion();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/al_key_entry.md
# al_key_entry

PS/2 time-entry controller for the alarm clock. It consumes scan-code bytes from the PS/2 keyboard receiver and interprets the key sequence T or A, then four digits, then Enter. It assembles a four-digit BCD HHMM value, validates it, and issues a one-cycle load strobe to the time or alarm registers in the top controller. During entry, the digit buffer drives the 7-segment display path.

## Interface
Parameters:
- TIMEOUT_SEC, default 10: number of sec_tick pulses with no accepted key before an entry is abandoned.

Ports:
- clk  input  1  system clock (MCLK domain).
- reset_n  input  1  asynchronous, active-low reset.
- key_code  input  8  PS/2 set-2 scan-code byte.
- key_valid  input  1  one-cycle strobe; key_code is valid in this cycle.
- sec_tick  input  1  one-cycle pulse, once per second, synchronous to clk.
- digits  output  16  {ms_hour, ls_hour, ms_min, ls_min}, BCD entry buffer.
- digit_count  output  3  number of digits entered, 0-4.
- entry_active  output  1  high in ENTRY_TIME or ENTRY_ALARM.
- entry_is_alarm  output  1  high in ENTRY_ALARM.
- load_time  output  1  one-cycle commit strobe for the time registers.
- load_alarm  output  1  one-cycle commit strobe for the alarm registers.
- error  output  1  one-cycle strobe on a rejected commit.

## Operation
- **Byte decode (all states).**
  - 0xF0 sets break_pending. The next valid byte clears break_pending and is otherwise ignored.
  - 0xE0 is ignored and does not affect break_pending.
  - All other bytes are make codes.
- **Digit keys.** 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
- **Command keys.** T=0x2C, A=0x1C, Enter=0x5A, Backspace=0x66, Esc=0x76.
- **State IDLE.**
  - T enters ENTRY_TIME; A enters ENTRY_ALARM.
  - On either, digits<=0, digit_count<=0, timer<=0.
  - All other make codes are ignored.
- **State ENTRY_TIME / ENTRY_ALARM.** Every make code resets the timer.
  - **Digit:** if digit_count<4, digits<={digits[11:0],d} and digit_count++. If digit_count==4, the digit is ignored.
  - **Backspace:** if digit_count>0, digits<={4'h0,digits[15:4]} and digit_count--. If digit_count==0, no change.
  - **Enter, valid:** requires digit_count==4, ms_hour<=2, ls_hour<=9, (ms_hour!=2 or ls_hour<=3), ms_min<=5, ls_min<=9. Pulses load_time or load_alarm according to state, then goes to IDLE.
  - **Enter, otherwise:** pulses error and stays in the same state with the buffer unchanged.
  - **Esc:** goes to IDLE. No load, no error.
  - **T or A:** restarts entry in the named mode and clears the buffer.
  - **Other codes:** ignored.
- **Timeout.** sec_tick with no key that cycle increments the timer. When it reaches TIMEOUT_SEC, go to IDLE with no load and no error.
- **Buffer hold.** digits holds its value in IDLE, including after a commit or abort. It is cleared only at entry start or reset.

## Timing
- **Reset values.** All outputs are registered and go to 0 on reset_n low:
  - state=IDLE, digits=16'h0000, digit_count=0, break_pending=0, timer=0.
  - load_time, load_alarm and error are all 0.
- **Latency.** An effect of key_valid in cycle N is visible in cycle N+1.
  - A strobe is high for exactly one cycle (N+1).
  - digits equals the committed value in cycle N+1 and stays stable afterwards.
- **Simultaneous events.** key_valid and sec_tick in the same cycle: a make code wins and the timer resets. A break-consumed byte or a prefix byte does not reset the timer, so the tick counts.
- **Mutual exclusion.** At most one of load_time, load_alarm and error is high in any cycle.
- **Reset mid-entry.** Asynchronous reset aborts the entry with no strobe; break_pending is cleared.
- **Input assumption.** key_valid is never high in consecutive cycles; the PS/2 byte rate guarantees this. Behaviour is nonetheless defined per cycle.
- **Timer width.** The timer is wide enough for TIMEOUT_SEC and saturates at the terminal count.

## Test plan
- **Time commit.** Keys T,1,2,3,4,Enter, each followed by F0 and the same code. Expect load_time for 1 cycle, digits=16'h1234, state IDLE, load_alarm=0, error=0.
- **Alarm commit with backspace.** Keys A,0,7,9,Backspace,3,0,Enter. Expect load_alarm once, digits=16'h0730.
- **Range checks.**
  - T,2,4,0,0,Enter: error pulse, still entry_active=1.
  - Then Backspace×4, then 2,3,5,9,Enter: load_time, digits=16'h2359.
  - T,1,2,6,0,Enter: error pulse.
- **Short entry and overflow.**
  - T,1,2,Enter: error, digit_count=2.
  - Then 3,4,5,Enter: the 5th digit is ignored; load_time with 16'h1234.
- **Break and extended prefixes.** Sequence T, F0 2C, 1, F0 16, E0 5A (keypad Enter) after four digits. Released codes never enter digits; keypad Enter commits.
- **Timeout and abort.**
  - TIMEOUT_SEC=3: T,5, then 3 sec_ticks with no keys. Expect return to IDLE with no strobe and digits held at 16'h0005.
  - A key arriving in the same cycle as the 3rd tick prevents the timeout.
  - Esc mid-entry returns to IDLE with no strobe.
  - reset_n pulsed low mid-entry clears all outputs immediately.
